// File: rtl/reg_bus_initiator_pkg.sv
// reg_bus_initiator_pkg: shared state encoding and command-format constants for the register bus initiator.
package reg_bus_initiator_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_LO, S_ADDR_HI, S_WR_DATA, S_WR_STB,
        S_RD_STB1, S_RD_STB2, S_RD_SEND, S_WR_ACK
    } state_e;
    localparam int RW_BIT = 7;
    localparam logic [7:0] ACK_BYTE = 8'h00;
endpackage

// File: rtl/reg_bus_initiator_if.sv
// reg_bus_initiator_if: command/response byte streams plus the register bus driven by the initiator.
interface reg_bus_initiator_if #(
    parameter int pADDR_WIDTH = 21,
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0] I_cmd_data;
    logic I_cmd_valid;
    logic O_cmd_ready;
    logic [7:0] O_rsp_data;
    logic O_rsp_valid;
    logic I_rsp_ready;
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic reg_read;
    logic reg_write;
    logic reg_addrvalid;
    logic O_busy;
    logic O_timeout;
    modport master (
        input  I_cmd_data, I_cmd_valid, I_rsp_ready, read_data,
        output O_cmd_ready, O_rsp_data, O_rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid, O_busy, O_timeout
    );
    modport slave (
        output I_cmd_data, I_cmd_valid, I_rsp_ready, read_data,
        input  O_cmd_ready, O_rsp_data, O_rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid, O_busy, O_timeout
    );
endinterface

// File: rtl/reg_bus_initiator_timeout.sv
// reg_bus_timeout: idle-cycle counter that pulses expire_o after pTIMEOUT enabled cycles without a clear.
module reg_bus_timeout #(
    parameter int pTIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int CW = $clog2(pTIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign expire_o = en_i && !clr_i && (cnt_q == CW'(pTIMEOUT - 1));
    assign cnt_d = (!en_i || clr_i || expire_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator: decodes command bytes into burst register reads/writes and returns read data or a write ack.
module reg_bus_initiator
    import reg_bus_initiator_pkg::*;
#(
    parameter int pADDR_WIDTH = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pTIMEOUT = 1024
) (
    input  logic usb_clk,
    input  logic reset_i,
    reg_bus_initiator_if.master bus
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    state_e state_q, state_d;
    logic rw_q, rw_d, av_q, av_d;
    logic [pBYTECNT_SIZE-1:0] len_q, len_d, bytecnt_q, bytecnt_d;
    logic [7:0] addr_lo_q, addr_lo_d, wdata_q, wdata_d, rsp_q, rsp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic cmd_hs, rsp_hs, last, expire;
    assign bus.O_cmd_ready = !reset_i && (state_q inside {S_IDLE, S_ADDR_LO, S_ADDR_HI, S_WR_DATA});
    assign bus.O_rsp_valid = state_q inside {S_RD_SEND, S_WR_ACK};
    assign bus.O_rsp_data = rsp_q;
    assign bus.reg_read = state_q inside {S_RD_STB1, S_RD_STB2};
    assign bus.reg_write = state_q == S_WR_STB;
    assign bus.reg_addrvalid = av_q;
    assign bus.reg_address = addr_q;
    assign bus.reg_bytecnt = bytecnt_q;
    assign bus.write_data = wdata_q;
    assign bus.O_busy = state_q != S_IDLE;
    assign bus.O_timeout = expire;
    assign cmd_hs = bus.I_cmd_valid && bus.O_cmd_ready;
    assign rsp_hs = bus.O_rsp_valid && bus.I_rsp_ready;
    assign last = bytecnt_q == len_q;
    reg_bus_timeout #(.pTIMEOUT(pTIMEOUT)) u_timeout (
        .clk_i(usb_clk),
        .rst_i(reset_i),
        .en_i(state_q inside {S_ADDR_LO, S_ADDR_HI, S_WR_DATA}),
        .clr_i(cmd_hs),
        .expire_o(expire)
    );
    always_comb begin
        state_d = state_q;
        rw_d = rw_q;
        len_d = len_q;
        addr_lo_d = addr_lo_q;
        addr_d = addr_q;
        av_d = av_q;
        bytecnt_d = bytecnt_q;
        wdata_d = wdata_q;
        rsp_d = rsp_q;
        case (state_q)
            S_IDLE: if (cmd_hs) begin
                rw_d = bus.I_cmd_data[RW_BIT];
                len_d = bus.I_cmd_data[pBYTECNT_SIZE-1:0];
                state_d = S_ADDR_LO;
            end
            S_ADDR_LO: if (cmd_hs) begin
                addr_lo_d = bus.I_cmd_data;
                state_d = S_ADDR_HI;
            end
            S_ADDR_HI: if (cmd_hs) begin
                addr_d = AW'({bus.I_cmd_data, addr_lo_q});
                av_d = 1'b1;
                bytecnt_d = '0;
                state_d = rw_q ? S_RD_STB1 : S_WR_DATA;
            end
            S_WR_DATA: if (cmd_hs) begin
                wdata_d = bus.I_cmd_data;
                state_d = S_WR_STB;
            end
            S_WR_STB: begin
                bytecnt_d = last ? bytecnt_q : bytecnt_q + 1'b1;
                rsp_d = last ? ACK_BYTE : rsp_q;
                state_d = last ? S_WR_ACK : S_WR_DATA;
            end
            S_WR_ACK: if (rsp_hs) begin
                av_d = 1'b0;
                state_d = S_IDLE;
            end
            S_RD_STB1: state_d = S_RD_STB2;
            S_RD_STB2: begin
                rsp_d = bus.read_data;
                state_d = S_RD_SEND;
            end
            S_RD_SEND: if (rsp_hs) begin
                av_d = !last;
                bytecnt_d = last ? bytecnt_q : bytecnt_q + 1'b1;
                state_d = last ? S_IDLE : S_RD_STB1;
            end
            default: state_d = S_IDLE;
        endcase
        // An abandoned command drops the burst; strobes already issued are not undone
        if (expire) begin
            state_d = S_IDLE;
            av_d = 1'b0;
        end
    end
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rw_q <= 1'b0;
            len_q <= '0;
            addr_lo_q <= '0;
            addr_q <= '0;
            av_q <= 1'b0;
            bytecnt_q <= '0;
            wdata_q <= '0;
            rsp_q <= '0;
        end else begin
            state_q <= state_d;
            rw_q <= rw_d;
            len_q <= len_d;
            addr_lo_q <= addr_lo_d;
            addr_q <= addr_d;
            av_q <= av_d;
            bytecnt_q <= bytecnt_d;
            wdata_q <= wdata_d;
            rsp_q <= rsp_d;
        end
    end
endmodule

// File: tb/tb_reg_bus_initiator.sv
// tb_reg_bus_initiator: directed command streams checked cycle by cycle against a transaction-level model.
module tb_reg_bus_initiator;
    localparam int TMO = 1024;
    typedef struct packed {
        logic [13:0] a;
        logic [6:0] c;
        logic [7:0] d;
    } ev_t;
    logic usb_clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rdata;
    logic [63:0] trace = "ArmTrace";
    logic [7:0] trace_exp [8] = '{8'h41, 8'h72, 8'h6d, 8'h54, 8'h72, 8'h61, 8'h63, 8'h65};
    int compared = 0, mismatched = 0;
    int n_wr = 0, n_rd = 0, n_rsp = 0, last_bc = -1;
    int bl = 0, nb = 0, idle = 0, rd_m = 0, wl = 0, rl = 0, len_m = 0;
    bit rw_m = 0, av_m = 0, wr_m = 0, rv_m = 0;
    ev_t wq[$], rq[$];
    logic [7:0] sq[$];

    reg_bus_initiator_if b ();
    reg_bus_initiator dut (.usb_clk(usb_clk), .reset_i(rst), .bus(b));
    assign b.read_data = rdata;
    always #5 usb_clk = ~usb_clk;

    // Register-file responder: data appears one cycle after reg_read, 0 when not selected
    function automatic logic [7:0] resp(input logic [13:0] a, input logic [6:0] c);
        if (a != 14'h0) return {1'b0, c} ^ 8'h5A;
        return (c < 7'd8) ? trace[63 - 8 * int'(c) -: 8] : 8'h00;
    endfunction
    always @(posedge usb_clk)
        rdata <= (rst || !b.reg_read || !b.reg_addrvalid) ? 8'h00 : resp(b.reg_address, b.reg_bytecnt);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        bit hs = 0;
        b.I_cmd_data = v;
        b.I_cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge usb_clk);
            hs = b.O_cmd_ready;
            tick();
        end
        b.I_cmd_valid = 1'b0;
        chk("send_accepted", hs, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (b.O_busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_in_budget", b.O_busy, 0);
    endtask

    task automatic monitor();
        bit prv_rd = 0, prv_rv = 0, prv_rr = 0, cmd_hs, rsp_hs, exp_to, av_n, rv_n;
        logic [7:0] prv_d = 0;
        ev_t e;
        forever begin
            @(negedge usb_clk);
            if (rst) begin
                bl = 0; nb = 0; idle = 0; rd_m = 0; wl = 0; rl = 0;
                av_m = 0; wr_m = 0; rv_m = 0; prv_rd = 0; prv_rv = 0;
                continue;
            end
            cmd_hs = b.I_cmd_valid && b.O_cmd_ready;
            rsp_hs = b.O_rsp_valid && b.I_rsp_ready;
            exp_to = bl > 0 && b.O_cmd_ready && !b.I_cmd_valid && idle + 1 == TMO;
            chk("reg_read", b.reg_read, rd_m > 0);
            chk("reg_write", b.reg_write, wr_m);
            chk("reg_addrvalid", b.reg_addrvalid, av_m);
            chk("rsp_valid", b.O_rsp_valid, rv_m);
            chk("timeout", b.O_timeout, exp_to);
            if (b.reg_read || b.reg_write) begin
                chk("rd_wr_overlap", b.reg_read && b.reg_write, 0);
                chk("strobe_addrvalid", b.reg_addrvalid, 1);
            end
            if (prv_rv && !prv_rr) chk("rsp_hold", b.O_rsp_data, prv_d);
            if (b.reg_write) begin
                n_wr++;
                chk("wr_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", b.reg_address, e.a);
                    chk("wr_bytecnt", b.reg_bytecnt, e.c);
                    chk("wr_data", b.write_data, e.d);
                end
            end
            if (b.reg_read && !prv_rd) begin
                n_rd++;
                last_bc = int'(b.reg_bytecnt);
                chk("rd_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    e = rq.pop_front();
                    chk("rd_addr", b.reg_address, e.a);
                    chk("rd_bytecnt", b.reg_bytecnt, e.c);
                end
            end
            if (rsp_hs) begin
                n_rsp++;
                chk("rsp_expected", sq.size() > 0, 1);
                if (sq.size() > 0) chk("rsp_data", b.O_rsp_data, sq.pop_front());
            end
            prv_rd = b.reg_read; prv_rv = b.O_rsp_valid; prv_rr = b.I_rsp_ready; prv_d = b.O_rsp_data;
            av_n = av_m;
            rv_n = rv_m && !rsp_hs;
            if (rd_m == 1) rv_n = 1;
            rd_m = rd_m > 0 ? rd_m - 1 : 0;
            if (wr_m) begin
                wl--;
                if (wl == 0) rv_n = 1;
            end
            wr_m = 0;
            if (cmd_hs) begin
                idle = 0;
                nb++;
                if (bl == 0) begin
                    rw_m = b.I_cmd_data[7];
                    len_m = int'(b.I_cmd_data[6:0]) + 1;
                    nb = 1;
                    bl = rw_m ? 2 : 2 + len_m;
                end else begin
                    bl--;
                    if (nb == 3) begin
                        av_n = 1;
                        if (rw_m) begin rd_m = 2; rl = len_m; end
                        else begin rl = 1; wl = len_m; end
                    end else if (nb > 3) wr_m = 1;
                end
            end else if (bl > 0 && b.O_cmd_ready) idle++;
            if (exp_to) begin bl = 0; idle = 0; av_n = 0; end
            if (rsp_hs) begin
                rl--;
                if (rl == 0) av_n = 0;
                else rd_m = 2;
            end
            av_m = av_n;
            rv_m = rv_n;
        end
    endtask

    initial begin
        int k, r0, w0, rd0;
        b.I_cmd_valid = 1'b0;
        b.I_cmd_data = 8'h00;
        b.I_rsp_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick();
        @(negedge usb_clk);
        chk("rst_cmd_ready", b.O_cmd_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge usb_clk);
        chk("rst_cmd_ready_after", b.O_cmd_ready, 1);
        chk("rst_outputs", {b.O_rsp_valid, b.O_rsp_data, b.reg_read, b.reg_write, b.reg_addrvalid, b.O_busy, b.O_timeout}, 0);
        chk("rst_bus", {b.reg_address, b.reg_bytecnt, b.write_data}, 0);
        tick();
        // Write burst of 8 to 0x24
        for (int i = 0; i < 8; i++) wq.push_back('{14'h24, 7'(i), 8'(8'h11 * (i + 1))});
        sq.push_back(8'h00);
        send(8'h07); send(8'h24); send(8'h00);
        for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)));
        wait_idle(50);
        chk("wr_burst_count", n_wr, 8);
        chk("wr_burst_ack", n_rsp, 1);
        // Trace read with response backpressure after the third byte
        for (int i = 0; i < 8; i++) begin
            rq.push_back('{14'h0, 7'(i), 8'h00});
            sq.push_back(trace_exp[i]);
        end
        send(8'h87); send(8'h00); send(8'h00);
        k = 0;
        while (n_rsp < 4 && k < 100) begin tick(); k++; end
        chk("bp_reached", n_rsp, 4);
        b.I_rsp_ready = 1'b0;
        repeat (5) tick();
        rd0 = n_rd;
        chk("bp_reads_before", rd0, 4);
        repeat (45) tick();
        @(negedge usb_clk);
        chk("bp_valid_held", b.O_rsp_valid, 1);
        chk("bp_no_extra_read", n_rd, rd0);
        tick();
        b.I_rsp_ready = 1'b1;
        wait_idle(100);
        chk("trace_reads", n_rd, 8);
        chk("trace_rsps", n_rsp, 9);
        // Timeout after one data byte of a 4-byte write
        wq.push_back('{14'h10, 7'd0, 8'hA5});
        w0 = n_wr;
        r0 = n_rsp;
        send(8'h03); send(8'h10); send(8'h00); send(8'hA5);
        k = 0;
        do begin
            @(negedge usb_clk);
            k++;
        end while (!b.O_timeout && k < 2000);
        chk("timeout_cycle", k, TMO + 1);
        repeat (3) tick();
        chk("timeout_busy", b.O_busy, 0);
        chk("timeout_writes", n_wr - w0, 1);
        chk("timeout_no_ack", n_rsp - r0, 0);
        // Next command decodes normally
        wq.push_back('{14'h155, 7'd0, 8'hDE});
        wq.push_back('{14'h155, 7'd1, 8'hAD});
        sq.push_back(8'h00);
        send(8'h01); send(8'h55); send(8'h01); send(8'hDE); send(8'hAD);
        wait_idle(50);
        chk("post_timeout_writes", n_wr - w0, 3);
        // Reset during the fourth byte slot of an 8-byte write
        for (int i = 0; i < 3; i++) wq.push_back('{14'h40, 7'(i), 8'(8'h31 + i)});
        r0 = n_rsp;
        send(8'h07); send(8'h40); send(8'h00);
        send(8'h31); send(8'h32); send(8'h33);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge usb_clk);
        chk("rst_mid_strobes", {b.reg_read, b.reg_write}, 0);
        chk("rst_mid_addrvalid", b.reg_addrvalid, 0);
        chk("rst_mid_rsp", b.O_rsp_valid, 0);
        tick();
        chk("rst_mid_wq_empty", wq.size(), 0);
        chk("rst_mid_no_rsp", n_rsp - r0, 0);
        // Maximum length read; address bits above the field are dropped
        r0 = n_rd;
        for (int i = 0; i < 128; i++) begin
            rq.push_back('{14'h33, 7'(i), 8'h00});
            sq.push_back(8'(i) ^ 8'h5A);
        end
        send(8'hFF); send(8'h33); send(8'hC0);
        wait_idle(1000);
        chk("max_reads", n_rd - r0, 128);
        chk("max_last_bytecnt", last_bc, 127);
        chk("max_addrvalid_low", b.reg_addrvalid, 0);
        repeat (3) tick();
        chk("end_wq_empty", wq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        chk("end_sq_empty", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
